// File: rtl/jtag_host_seq.sv
// IEEE 1149.1 host sequencer: runs TLR / shift IR / shift DR / RTI-idle commands and returns captured TDO.
// Optional macro JTAG_HOST_LEN_CHECK_EN adds rsp_err and rejects out-of-range shift/idle lengths.
module jtag_host_seq #(
  parameter int TCK_DIV = 4,
  parameter int MAX_LEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
`ifdef JTAG_HOST_LEN_CHECK_EN
  output logic               rsp_err,
`endif
  output logic               jtag_tck,
  output logic               jtag_tms,
  output logic               jtag_tdi,
  input  logic               jtag_tdo
);

  localparam int IW = $clog2(MAX_LEN);
  localparam int DW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [1:0] OP_TLR = 2'd0;
  localparam logic [1:0] OP_IR  = 2'd1;
  localparam logic [1:0] OP_DR  = 2'd2;
  localparam logic [1:0] OP_RTI = 2'd3;

  typedef enum logic [2:0] {IDLE, PRE, SHIFT, POST, RSP} state_t;

  state_t               state_q, state_n;
  logic [DW-1:0]        div_q, div_n;
  logic                 tck_q, tck_n, tms_q, tms_n, tdi_q, tdi_n;
  logic [5:0]           cnt_q, cnt_n, n_q, n_n;
  logic [1:0]           op_q, op_n;
  logic [MAX_LEN-1:0]   data_q, data_n, rdata_q, rdata_n;
  logic                 rvalid_q, rvalid_n;

  logic                 active, div_tc, rise, fall, last_shift, pre_last, len_bad;
  logic [5:0]           len_eff, cnt_inc;

  // A length field of 0 selects the full 32-bit shift; upper bit is dropped.
  assign len_eff = (cmd_len[4:0] == 5'd0) ? 6'd32 : {1'b0, cmd_len[4:0]};

`ifdef JTAG_HOST_LEN_CHECK_EN
  logic err_q;
  assign len_bad = (cmd_op != OP_TLR) && ((cmd_len == 6'd0) || (int'(cmd_len) > MAX_LEN));
  assign rsp_err = err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if (state_q == IDLE && cmd_valid) err_q <= len_bad;
  end
`else
  logic unused_len_msb;
  assign unused_len_msb = cmd_len[5];
  assign len_bad = 1'b0;
`endif

  assign active     = (state_q == PRE) || (state_q == SHIFT) || (state_q == POST);
  assign div_tc     = (div_q == DW'(TCK_DIV - 1));
  assign rise       = active && div_tc && !tck_q;
  assign fall       = active && div_tc && tck_q;
  assign cnt_inc    = cnt_q + 6'd1;
  assign last_shift = (cnt_q == n_q - 6'd1);
  assign pre_last   = (cnt_q == ((op_q == OP_DR) ? 6'd2 : 6'd3));

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = rvalid_q;
  assign rsp_data  = rdata_q;
  assign jtag_tck  = tck_q;
  assign jtag_tms  = tms_q;
  assign jtag_tdi  = tdi_q;

  always_comb begin
    state_n  = state_q;
    div_n    = div_q;
    tck_n    = tck_q;
    tms_n    = tms_q;
    tdi_n    = tdi_q;
    cnt_n    = cnt_q;
    n_n      = n_q;
    op_n     = op_q;
    data_n   = data_q;
    rdata_n  = rdata_q;
    rvalid_n = rvalid_q;

    if (active) begin
      if (div_tc) begin
        div_n = '0;
        tck_n = ~tck_q;
      end else begin
        div_n = div_q + DW'(1);
      end
    end else begin
      div_n = '0;
      tck_n = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_n    = cmd_op;
          n_n     = len_eff;
          data_n  = cmd_data;
          rdata_n = '0;
          cnt_n   = '0;
          tdi_n   = 1'b0;
          if (len_bad) begin
            state_n = RSP;
          end else if (cmd_op == OP_RTI) begin
            state_n = SHIFT;
            tms_n   = 1'b0;
          end else begin
            state_n = PRE;
            tms_n   = 1'b1;
          end
        end
      end
      PRE: begin
        if (fall) begin
          if (pre_last) begin
            cnt_n = '0;
            if (op_q == OP_TLR) begin
              // TLR tail (1,0) reuses POST to land in Run-Test/Idle.
              state_n = POST;
              tms_n   = 1'b1;
            end else begin
              state_n = SHIFT;
              tms_n   = (n_q == 6'd1);
              tdi_n   = data_q[0];
            end
          end else begin
            cnt_n = cnt_inc;
            tms_n = (op_q == OP_TLR) || (op_q == OP_IR && cnt_q == 6'd0);
          end
        end
      end
      SHIFT: begin
        if (rise && op_q != OP_RTI) rdata_n[cnt_q[IW-1:0]] = jtag_tdo;
        if (fall) begin
          if (last_shift) begin
            cnt_n = '0;
            if (op_q == OP_RTI) begin
              state_n = RSP;
            end else begin
              state_n = POST;
              tms_n   = 1'b1;
              tdi_n   = 1'b0;
            end
          end else begin
            cnt_n = cnt_inc;
            if (op_q != OP_RTI) begin
              tms_n = (cnt_inc == n_q - 6'd1);
              tdi_n = data_q[cnt_inc[IW-1:0]];
            end
          end
        end
      end
      POST: begin
        if (fall) begin
          if (cnt_q == 6'd0) begin
            cnt_n = 6'd1;
            tms_n = 1'b0;
          end else begin
            state_n = RSP;
          end
        end
      end
      RSP: begin
        if (!rvalid_q) begin
          rvalid_n = 1'b1;
        end else if (rsp_ready) begin
          rvalid_n = 1'b0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      tck_q    <= 1'b0;
      tms_q    <= 1'b1;
      tdi_q    <= 1'b0;
      cnt_q    <= '0;
      n_q      <= '0;
      op_q     <= OP_TLR;
      data_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      div_q    <= div_n;
      tck_q    <= tck_n;
      tms_q    <= tms_n;
      tdi_q    <= tdi_n;
      cnt_q    <= cnt_n;
      n_q      <= n_n;
      op_q     <= op_n;
      data_q   <= data_n;
      rdata_q  <= rdata_n;
      rvalid_q <= rvalid_n;
    end
  end

endmodule
